// File: rtl/fas_pkg.sv
// Shared constants, frame types and FSM encoding for the FAS frequency-analysis stage.
package fas_pkg;

  localparam int unsigned FFT_BINS = 16;
  localparam int unsigned DW       = 16;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef cplx_t [FFT_BINS-1:0] frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fa_state_t;

endpackage

// File: rtl/fas_bin_power.sv
// Squared magnitude of one complex bin: re*re + im*im, returned as an unsigned 2*DW value.
module fas_bin_power #(
  parameter int unsigned DW = 16
) (
  input  logic signed [DW-1:0]   re_i,
  input  logic signed [DW-1:0]   im_i,
  output logic        [2*DW-1:0] pow_o
);

  logic signed [2*DW-1:0] rr;
  logic signed [2*DW-1:0] ii;

  // Each square is non-negative and at most 2^(2DW-2), so the sum fits 2*DW unsigned bits.
  assign rr    = re_i * re_i;
  assign ii    = im_i * im_i;
  assign pow_o = $unsigned(rr) + $unsigned(ii);

endmodule

// File: rtl/fas_freq_analyzer.sv
// Peak-bin finder for 16-bin FFT frames: one bin power per cycle, two-slot frame buffer.
module fas_freq_analyzer
  import fas_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic            done,
  output logic [3:0]      freq,
  output logic [2*DW-1:0] max_pow,
  output logic            overrun
);

  localparam int unsigned W2 = 2 * DW;

  typedef logic [FFT_BINS-1:0][W2-1:0] slot_t;

  slot_t     in_frame;
  slot_t     act_q, act_d;
  slot_t     pnd_q, pnd_d;
  logic      pnd_full_q, pnd_full_d;
  fa_state_t state_q, state_d;
  logic [3:0] bin_q, bin_d;
  logic      ovr_q, ovr_d;

  logic [W2-1:0] cur_bin;
  logic [W2-1:0] pow_w;

  logic [W2-1:0] pow_q;
  logic          p_vld_q;
  logic [3:0]    p_idx_q;
  logic [W2-1:0] best_pow_q;
  logic [3:0]    best_idx_q;
  logic          fin_q;
  logic          done_q;
  logic [3:0]    freq_q;
  logic [W2-1:0] max_pow_q;

  assign in_frame = {fft_d15, fft_d14, fft_d13, fft_d12, fft_d11, fft_d10, fft_d9, fft_d8,
                     fft_d7,  fft_d6,  fft_d5,  fft_d4,  fft_d3,  fft_d2,  fft_d1, fft_d0};

  assign cur_bin = act_q[bin_q];

  fas_bin_power #(.DW(DW)) u_bin_power (
    .re_i  (cur_bin[W2-1:DW]),
    .im_i  (cur_bin[DW-1:0]),
    .pow_o (pow_w)
  );

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    act_d      = act_q;
    pnd_d      = pnd_q;
    pnd_full_d = pnd_full_q;
    ovr_d      = ovr_q;
    case (state_q)
      IDLE: begin
        if (fft_valid) begin
          act_d   = in_frame;
          bin_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        bin_d = bin_q + 4'd1;
        if (bin_q == 4'd15) begin
          // Pending frame retires into active first; a same-edge arrival then refills pending.
          if (pnd_full_q) begin
            act_d = pnd_q;
            if (fft_valid) pnd_d = in_frame;
            else           pnd_full_d = 1'b0;
          end else if (fft_valid) begin
            act_d = in_frame;
          end else begin
            state_d = IDLE;
          end
        end else if (fft_valid) begin
          if (pnd_full_q) begin
            ovr_d = 1'b1;
          end else begin
            pnd_d      = in_frame;
            pnd_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      act_q      <= '0;
      pnd_q      <= '0;
      pnd_full_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      act_q      <= act_d;
      pnd_q      <= pnd_d;
      pnd_full_q <= pnd_full_d;
      ovr_q      <= ovr_d;
    end
  end

  // Stage 1 registers the bin power, stage 2 tracks the running maximum, stage 3 publishes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pow_q      <= '0;
      p_vld_q    <= 1'b0;
      p_idx_q    <= '0;
      best_pow_q <= '0;
      best_idx_q <= '0;
      fin_q      <= 1'b0;
      done_q     <= 1'b0;
      freq_q     <= '0;
      max_pow_q  <= '0;
    end else begin
      p_vld_q <= (state_q == RUN);
      p_idx_q <= bin_q;
      if (state_q == RUN) pow_q <= pow_w;

      if (p_vld_q && ((p_idx_q == 4'd0) || (pow_q > best_pow_q))) begin
        best_pow_q <= pow_q;
        best_idx_q <= p_idx_q;
      end
      fin_q <= p_vld_q && (p_idx_q == 4'd15);

      done_q <= fin_q;
      if (fin_q) begin
        freq_q    <= best_idx_q;
        max_pow_q <= best_pow_q;
      end
    end
  end

  assign done    = done_q;
  assign freq    = freq_q;
  assign max_pow = max_pow_q;
  assign overrun = ovr_q;

endmodule
